// File: rtl/button_conditioner.sv
// Per-button 2-flop synchroniser, debounce FSM and one-cycle press/release pulses.
// Optional macro BUTTON_ACTIVE_LOW_EN: raw inputs are inverted (raw 0 = pressed).
module button_conditioner #(
  parameter int CLK_RATE_HZ = 1_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int NUM_BUTTONS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] buttons_pressed,
  output logic [NUM_BUTTONS-1:0] buttons_released
);

  localparam int DEBOUNCE_TICKS = (CLK_RATE_HZ / 1000) * DEBOUNCE_MS;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit 1 of the state encoding is the debounced level.
  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] PEND_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] PEND_LOW  = 2'd3;

  if (DEBOUNCE_TICKS < 2) begin : g_ticks_check
    $error("button_conditioner: DEBOUNCE_TICKS must be at least 2");
  end

  logic [NUM_BUTTONS-1:0] raw_pol;
  logic [NUM_BUTTONS-1:0] sync1_reg;
  logic [NUM_BUTTONS-1:0] sync2_reg;

`ifdef BUTTON_ACTIVE_LOW_EN
  assign raw_pol = ~buttons_raw;
`else
  assign raw_pol = buttons_raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_pol;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      logic [1:0]       state_reg;
      logic [1:0]       state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             pressed_reg;
      logic             pressed_next;
      logic             released_reg;
      logic             released_next;
      logic             in_bit;

      assign in_bit = sync2_reg[gi];

      always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pressed_next  = 1'b0;
        released_next = 1'b0;
        case (state_reg)
          IDLE_LOW: begin
            if (in_bit) begin
              state_next = PEND_HIGH;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next = '0;
            end
          end
          PEND_HIGH: begin
            if (!in_bit) begin
              state_next = IDLE_LOW;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next   = IDLE_HIGH;
              pressed_next = 1'b1;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          IDLE_HIGH: begin
            if (!in_bit) begin
              state_next = PEND_LOW;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next = '0;
            end
          end
          PEND_LOW: begin
            if (in_bit) begin
              state_next = IDLE_HIGH;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_MAX) begin
              state_next    = IDLE_LOW;
              released_next = 1'b1;
              cnt_next      = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg    <= IDLE_LOW;
          cnt_reg      <= '0;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
        end else begin
          state_reg    <= state_next;
          cnt_reg      <= cnt_next;
          pressed_reg  <= pressed_next;
          released_reg <= released_next;
        end
      end

      assign buttons_level[gi]    = state_reg[1];
      assign buttons_pressed[gi]  = pressed_reg;
      assign buttons_released[gi] = released_reg;
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner with a pulse scoreboard.
// Stimulus is written in logical (pressed = 1) terms and mapped to raw polarity.
module tb_button_conditioner;

  localparam int TICKS = 4;
  // Raw drive -> sync1 -> sync2 -> TICKS+1 stable FSM samples.
  localparam int LAT = TICKS + 3;
  localparam int NSTEPS = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] buttons_raw;
  logic [1:0] buttons_level;
  logic [1:0] buttons_pressed;
  logic [1:0] buttons_released;

  button_conditioner #(
    .CLK_RATE_HZ(1000),
    .DEBOUNCE_MS(4),
    .NUM_BUTTONS(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .buttons_raw      (buttons_raw),
    .buttons_level    (buttons_level),
    .buttons_pressed  (buttons_pressed),
    .buttons_released (buttons_released)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] raw;
    int         hold;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] level;
  } step_t;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
  } ev_t;

  step_t steps [0:NSTEPS-1];
  ev_t   sb [$];
  ev_t   mon_ev;
  int    checks = 0;
  int    failures = 0;

  function automatic logic [1:0] drv(input logic [1:0] v);
`ifdef BUTTON_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s cyc=%0d pending_events=%0d required=0 (next expected at cyc %0d)",
               name, cyc, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic push_ev(input int at, input logic [1:0] p, input logic [1:0] r);
    ev_t e;
    e.cyc = at;
    e.p   = p;
    e.r   = r;
    sb.push_back(e);
  endtask

  // Every pulse observed must match the head of the scoreboard in cycle and value.
  always @(negedge clk) begin
    if ((buttons_pressed | buttons_released) != 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d pressed=%b released=%b required=none",
                 cyc, buttons_pressed, buttons_released);
      end else begin
        mon_ev = sb.pop_front();
        if (mon_ev.cyc != cyc || mon_ev.p !== buttons_pressed || mon_ev.r !== buttons_released) begin
          failures++;
          $display("FAIL pulse cyc=%0d pressed=%b released=%b required cyc=%0d pressed=%b released=%b",
                   cyc, buttons_pressed, buttons_released, mon_ev.cyc, mon_ev.p, mon_ev.r);
        end else begin
          $display("pulse ok cyc=%0d pressed=%b released=%b", cyc, buttons_pressed, buttons_released);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    //            raw    hold press  rel    level
    steps[0]  = '{2'b00, 10, 2'b00, 2'b00, 2'b00};  // idle
    steps[1]  = '{2'b01, 20, 2'b01, 2'b00, 2'b01};  // clean press ch0
    steps[2]  = '{2'b00, 20, 2'b00, 2'b01, 2'b00};  // clean release ch0
    steps[3]  = '{2'b01,  2, 2'b00, 2'b00, 2'b00};  // bounce
    steps[4]  = '{2'b00,  2, 2'b00, 2'b00, 2'b00};
    steps[5]  = '{2'b01,  2, 2'b00, 2'b00, 2'b00};
    steps[6]  = '{2'b00,  2, 2'b00, 2'b00, 2'b00};
    steps[7]  = '{2'b01, 20, 2'b01, 2'b00, 2'b01};  // final rise accepted
    steps[8]  = '{2'b00, 20, 2'b00, 2'b01, 2'b00};
    steps[9]  = '{2'b10,  3, 2'b00, 2'b00, 2'b00};  // 3-cycle glitch ch1
    steps[10] = '{2'b00, 15, 2'b00, 2'b00, 2'b00};
    steps[11] = '{2'b10,  4, 2'b00, 2'b00, 2'b00};  // exactly TICKS: rejected
    steps[12] = '{2'b00, 10, 2'b00, 2'b00, 2'b00};
    steps[13] = '{2'b10,  5, 2'b10, 2'b00, 2'b00};  // TICKS+1: accepted
    steps[14] = '{2'b00, 15, 2'b00, 2'b10, 2'b00};  // release at minimum spacing
    steps[15] = '{2'b11, 20, 2'b11, 2'b00, 2'b11};  // simultaneous press
    steps[16] = '{2'b00, 20, 2'b00, 2'b11, 2'b00};  // simultaneous release

    reset = 1'b1;
    buttons_raw = drv(2'b00);
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {buttons_level, buttons_pressed, buttons_released}, 6'b0);
    end
    reset = 1'b0;

    for (int i = 0; i < NSTEPS; i++) begin
      buttons_raw = drv(steps[i].raw);
      if ((steps[i].press | steps[i].rel) != 2'b00)
        push_ev(cyc + LAT, steps[i].press, steps[i].rel);
      repeat (steps[i].hold) @(negedge clk);
      check($sformatf("step%0d_level", i), {4'b0, buttons_level}, {4'b0, steps[i].level});
    end
    repeat (10) @(negedge clk);
    check_drained("table_drained");

    // Reset while ch0 is pending high with raw held: pending press discarded.
    buttons_raw = drv(2'b01);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_reset_outputs", {buttons_level, buttons_pressed, buttons_released}, 6'b0);
    end
    reset = 1'b0;
    c0 = cyc;
    push_ev(c0 + TICKS + 3, 2'b01, 2'b00);
    repeat (TICKS + 2) @(negedge clk);
    check("post_reset_level_before", {4'b0, buttons_level}, 6'b0);
    repeat (18) @(negedge clk);
    check("post_reset_level", {4'b0, buttons_level}, 6'b000001);
    buttons_raw = drv(2'b00);
    push_ev(cyc + LAT, 2'b00, 2'b01);
    repeat (20) @(negedge clk);
    check("post_reset_release_level", {4'b0, buttons_level}, 6'b0);
    check_drained("reset_seq_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
